mmio_sig_ctrl: RTL and testbench
================================

# mmio_sig_ctrl

Synthesizable controller for the tiny-SoC MMIO signature channel. It decodes core writes to the signature window (stop, trap, integer/float register dump, register stream) and runs the run/drain/done sequence with a SIMLEN cycle limit. It accumulates the per-cycle coverage vector and queues dump/stop/trap events, with taint, to a host-side consumer through a valid/ready port. It sits beside `top_tiny_soc` on the MMIO request bus and replaces per-cycle bench polling with a registered event stream.

## Interface
- `ADDR_W`, 32, MMIO address width
- `DATA_W`, 64, MMIO write-data width
- `COV_W`, 7283, coverage vector width
- `DRAIN_CYCLES`, 50, cycles kept running after a stop/trap
- `FIFO_DEPTH`, 4, event queue depth (power of two)
- `clk_i` in 1 clock; single clock domain
- `rst_i` in 1 reset, synchronous, active-high
- `start_i` in 1 one-cycle pulse, IDLE -> RUN
- `cfg_simlen_i` in 32 cycle limit; 0 = unlimited
- `cfg_stop_on_trap_i` in 1 trap starts drain when 1
- `mmio_req_i`, `mmio_we_i` in 1 each, MMIO request and write-enable
- `mmio_addr_i` in ADDR_W MMIO address
- `mmio_wdata_i`, `mmio_wdata_t0_i` in DATA_W write data and its taint
- `cov_i` in COV_W per-cycle coverage vector
- `ev_valid_o` out 1, `ev_ready_i` in 1: event handshake
- `ev_kind_o` out 3: REG=0, FREG=1, STREAM=2, STOP=3, TRAP=4
- `ev_idx_o` out 16 dump index
- `ev_data_o`, `ev_data_t0_o` out DATA_W captured wdata and taint
- `cov_acc_o` out COV_W OR-accumulated coverage
- `step_o` out 32 counted steps
- `state_o` out 2: IDLE=0, RUN=1, DRAIN=2, DONE=3
- `done_o` out 1 level, high in DONE
- `cause_o` out 2: NONE=0, STOP=1, TRAP=2, SIMLEN=3
- `ovf_o` out 1 sticky: an event was dropped

## Operation
- Reset values: IDLE; all counters 0; cov_acc 0; FIFO empty; `ev_valid_o`, `done_o`, `ovf_o` 0; `cause_o` NONE.
- Address match is exact on the full `ADDR_W` bits: STOP 0x6000_0000, TRAP 0x6000_0008, REG 0x6000_0010, FREG 0x6000_0018, STREAM 0x6000_0020.
- STOP, REG, FREG and STREAM require `mmio_req_i && mmio_we_i`. TRAP requires only `mmio_req_i`.
- IDLE: ignores the bus. `start_i` moves to RUN.
- RUN, per cycle, evaluated in this order:
  - REG/FREG/STREAM write: push an event carrying the current index, then increment that index. REG index starts at 1; FREG and STREAM start at 0. Indices wrap modulo 2^16.
  - STOP: push a STOP event, set cause STOP, load drain = DRAIN_CYCLES, go to DRAIN.
  - TRAP: push a TRAP event. If `cfg_stop_on_trap_i`, set cause TRAP and enter DRAIN. Otherwise stay in RUN.
  - SIMLEN: if `cfg_simlen_i != 0 && step == cfg_simlen_i-1`, go to DONE with cause SIMLEN. This overrides a STOP/TRAP in the same cycle (the event is still pushed; cause is SIMLEN).
- DRAIN:
  - Dump, stop and trap writes are ignored.
  - If drain == 0, go to DONE; otherwise decrement drain.
  - The SIMLEN check also applies and goes to DONE with cause SIMLEN.
- Accumulate in RUN/DRAIN (cycle not moving to DONE): `cov_acc |= cov_i`, `step++`.
- The cycle that moves to DONE is not accumulated.
- DONE is terminal until `rst_i`. It holds `cov_acc`, `step` and `cause`. The FIFO keeps draining to the consumer.
- FIFO full with no pop in that cycle: the new event is dropped and `ovf_o` sets. The index still increments.
- Full FIFO with a pop and a push in the same cycle: both happen and there is no drop.
- `rst_i` asserted in any state (mid-drain included) returns everything to reset values on the next edge. Queued events are lost.

## Timing
- The event from an MMIO cycle N is visible on `ev_valid_o` at N+1 if the FIFO was empty (registered, FWFT).
- `ev_*` outputs hold stable while `ev_valid_o && !ev_ready_i`.
- `state_o`, `done_o` and `cause_o` update one edge after the triggering cycle.
- A STOP at cycle N gives `done_o` = 1 at N+DRAIN_CYCLES+2.
- Throughput: one event per cycle.

## Structure
- Package `mmio_sig_pkg`: signature address constants, and the `state_e`, `ev_kind_e`, `cause_e` enums.
- Sub-module `sig_event_fifo`: depth `FIFO_DEPTH`, FWFT, payload {kind, idx, data, data_t0}, with full/empty flags.
- Top: FSM, address decode, three index counters, drain counter, step counter, coverage accumulator.

## Test plan
- REG writes 0xA, 0xB to 0x6000_0010 with t0 = 0x1, `ev_ready_i` = 1 -> two REG events idx 1, 2, data 0xA/0xB, t0 0x1; FREG/STREAM indices unchanged.
- STOP at step 5, DRAIN_CYCLES = 50 -> STOP event; `done_o` rises 52 cycles after the write; `cause_o` = STOP; `step_o` = 56.
- TRAP with `cfg_stop_on_trap_i` = 0 -> TRAP event, stays RUN. With 1 -> DRAIN, cause TRAP. A REG write during DRAIN produces no event.
- `cfg_simlen_i` = 10, `cov_i` = one-hot bit k at step k -> DONE, cause SIMLEN, `step_o` = 9, `cov_acc_o` bits 0..8 set, bit 9 clear.
- `ev_ready_i` = 0, six STREAM writes -> four events queued, `ovf_o` = 1. Releasing ready delivers idx 0..3; the next STREAM write gets idx 6.
- `rst_i` pulsed mid-DRAIN -> IDLE, FIFO empty, `cov_acc_o` 0, `ovf_o` 0. After `start_i`, the REG index restarts at 1.

Source files
------------

// File: rtl/mmio_sig_pkg.sv
// mmio_sig_pkg
// Shared definitions for the MMIO signature channel:
//   - signature window address constants (full-width exact match)
//   - state_e   : controller sequence state (IDLE/RUN/DRAIN/DONE)
//   - ev_kind_e : kind tag carried by every queued event
//   - cause_e   : why the controller reached DONE
`timescale 1ns/1ps
package mmio_sig_pkg;

  localparam logic [31:0] SIG_ADDR_STOP   = 32'h6000_0000;
  localparam logic [31:0] SIG_ADDR_TRAP   = 32'h6000_0008;
  localparam logic [31:0] SIG_ADDR_REG    = 32'h6000_0010;
  localparam logic [31:0] SIG_ADDR_FREG   = 32'h6000_0018;
  localparam logic [31:0] SIG_ADDR_STREAM = 32'h6000_0020;

  // Dump channels, indexed so that the channel number equals its event kind.
  localparam int NUM_DUMP = 3;
  localparam logic [NUM_DUMP-1:0][31:0] SIG_DUMP_ADDR =
    {SIG_ADDR_STREAM, SIG_ADDR_FREG, SIG_ADDR_REG};

  localparam int IDX_W  = 16;
  localparam int KIND_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [KIND_W-1:0] {
    EV_REG    = 3'd0,
    EV_FREG   = 3'd1,
    EV_STREAM = 3'd2,
    EV_STOP   = 3'd3,
    EV_TRAP   = 3'd4
  } ev_kind_e;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'd0,
    CAUSE_STOP   = 2'd1,
    CAUSE_TRAP   = 2'd2,
    CAUSE_SIMLEN = 2'd3
  } cause_e;

endpackage

// File: rtl/sig_event_fifo.sv
// sig_event_fifo
// First-word-fall-through event queue for the signature channel.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   push_i + push_kind/idx/data/data_t0_i   event to enqueue
//   pop_i                        consumer takes the head this cycle
//   valid_o + head_*_o           head of queue (valid while not empty)
//   full_o, empty_o              occupancy flags
//   drop_o                       push rejected because the queue was full
//                                and nothing left it in the same cycle
`timescale 1ns/1ps
module sig_event_fifo
  import mmio_sig_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  ev_kind_e          push_kind_i,
  input  logic [IDX_W-1:0]  push_idx_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic [DATA_W-1:0] push_data_t0_i,
  input  logic              pop_i,
  output logic              valid_o,
  output ev_kind_e          head_kind_o,
  output logic [IDX_W-1:0]  head_idx_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [DATA_W-1:0] head_data_t0_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              drop_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int PAY_W = KIND_W + IDX_W + 2 * DATA_W;

  logic [PAY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             pop_ok;
  logic             push_ok;
  logic [PAY_W-1:0] head_payload;

  assign empty_o = (count_reg == '0);
  assign full_o  = (count_reg == (PTR_W + 1)'(DEPTH));
  assign valid_o = !empty_o;

  // A pop frees the slot the write pointer is aimed at when full, so a
  // simultaneous push and pop on a full queue both proceed.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign drop_o  = push_i && !push_ok;

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= {push_kind_i, push_idx_i, push_data_i, push_data_t0_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push_ok && !pop_ok)      count_reg <= count_reg + (PTR_W + 1)'(1);
      else if (pop_ok && !push_ok) count_reg <= count_reg - (PTR_W + 1)'(1);
    end
  end

  assign head_payload   = mem[rd_ptr_reg];
  assign head_kind_o    = ev_kind_e'(head_payload[PAY_W-1 -: KIND_W]);
  assign head_idx_o     = head_payload[2*DATA_W +: IDX_W];
  assign head_data_o    = head_payload[DATA_W +: DATA_W];
  assign head_data_t0_o = head_payload[0 +: DATA_W];

endmodule

// File: rtl/mmio_sig_ctrl.sv
// mmio_sig_ctrl
// Watches the MMIO request bus for writes into the signature window,
// sequences IDLE -> RUN -> DRAIN -> DONE, accumulates coverage and queues
// dump/stop/trap events (with taint) to a host consumer.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i                 one-cycle pulse, IDLE -> RUN
//   cfg_simlen_i            cycle limit (0 = unlimited)
//   cfg_stop_on_trap_i      trap write starts the drain when set
//   mmio_*                  request, write enable, address, data, data taint
//   cov_i                   per-cycle coverage vector
//   ev_valid_o/ev_ready_i   event handshake; ev_kind/idx/data/data_t0_o payload
//   cov_acc_o, step_o       OR-accumulated coverage and counted steps
//   state_o, done_o, cause_o, ovf_o   status
`timescale 1ns/1ps
module mmio_sig_ctrl
  import mmio_sig_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 64,
  parameter int COV_W        = 7283,
  parameter int DRAIN_CYCLES = 50,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [31:0]       cfg_simlen_i,
  input  logic              cfg_stop_on_trap_i,
  input  logic              mmio_req_i,
  input  logic              mmio_we_i,
  input  logic [ADDR_W-1:0] mmio_addr_i,
  input  logic [DATA_W-1:0] mmio_wdata_i,
  input  logic [DATA_W-1:0] mmio_wdata_t0_i,
  input  logic [COV_W-1:0]  cov_i,
  output logic              ev_valid_o,
  input  logic              ev_ready_i,
  output logic [2:0]        ev_kind_o,
  output logic [15:0]       ev_idx_o,
  output logic [DATA_W-1:0] ev_data_o,
  output logic [DATA_W-1:0] ev_data_t0_o,
  output logic [COV_W-1:0]  cov_acc_o,
  output logic [31:0]       step_o,
  output logic [1:0]        state_o,
  output logic              done_o,
  output logic [1:0]        cause_o,
  output logic              ovf_o
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  state_e              state_reg;
  cause_e              cause_reg;
  logic [DRAIN_W-1:0]  drain_reg;
  logic [31:0]         step_reg;
  logic [COV_W-1:0]    cov_acc_reg;
  logic                done_reg;
  logic                ovf_reg;

  logic                mmio_wr;
  logic                run_cycle;
  logic                hit_stop;
  logic                hit_trap;
  logic                simlen_hit;
  logic [NUM_DUMP-1:0] hit_dump;
  logic [NUM_DUMP-1:0][IDX_W-1:0] dump_idx;

  logic                ev_push;
  ev_kind_e            ev_push_kind;
  logic [IDX_W-1:0]    ev_push_idx;
  ev_kind_e            head_kind;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_drop;

  assign mmio_wr   = mmio_req_i && mmio_we_i;
  assign run_cycle = (state_reg == ST_RUN);
  assign hit_stop  = mmio_wr && (mmio_addr_i == ADDR_W'(SIG_ADDR_STOP));
  // A trap is signalled by any access to its address, read or write.
  assign hit_trap  = mmio_req_i && (mmio_addr_i == ADDR_W'(SIG_ADDR_TRAP));
  assign simlen_hit = (cfg_simlen_i != 32'd0) && (step_reg == cfg_simlen_i - 32'd1);

  // One index counter per dump channel; REG numbering starts at 1, the
  // others at 0. The index advances on every accepted write even if the
  // event itself is dropped by a full queue.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DUMP; gi++) begin : g_dump
      logic [IDX_W-1:0] idx_reg;
      assign hit_dump[gi] = mmio_wr && (mmio_addr_i == ADDR_W'(SIG_DUMP_ADDR[gi]));
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          idx_reg <= (gi == 0) ? IDX_W'(1) : IDX_W'(0);
        end else if (run_cycle && hit_dump[gi]) begin
          idx_reg <= idx_reg + IDX_W'(1);
        end
      end
      assign dump_idx[gi] = idx_reg;
    end
  endgenerate

  // Event selection; the window addresses are distinct so at most one hits.
  always_comb begin
    ev_push      = 1'b0;
    ev_push_kind = EV_REG;
    ev_push_idx  = '0;
    if (run_cycle) begin
      if (hit_stop) begin
        ev_push      = 1'b1;
        ev_push_kind = EV_STOP;
      end else if (hit_trap) begin
        ev_push      = 1'b1;
        ev_push_kind = EV_TRAP;
      end
      for (int i = 0; i < NUM_DUMP; i++) begin
        if (hit_dump[i]) begin
          ev_push      = 1'b1;
          ev_push_kind = ev_kind_e'(3'(i));
          ev_push_idx  = dump_idx[i];
        end
      end
    end
  end

  assign fifo_pop = ev_valid_o && ev_ready_i;

  sig_event_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .push_i         (ev_push),
    .push_kind_i    (ev_push_kind),
    .push_idx_i     (ev_push_idx),
    .push_data_i    (mmio_wdata_i),
    .push_data_t0_i (mmio_wdata_t0_i),
    .pop_i          (fifo_pop),
    .valid_o        (ev_valid_o),
    .head_kind_o    (head_kind),
    .head_idx_o     (ev_idx_o),
    .head_data_o    (ev_data_o),
    .head_data_t0_o (ev_data_t0_o),
    .full_o         (fifo_full),
    .empty_o        (fifo_empty),
    .drop_o         (fifo_drop)
  );

  // Sequencer. The cycle that enters DONE is never accumulated, and a
  // SIMLEN hit takes priority over stop/trap/drain-expiry for the cause.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= ST_IDLE;
      cause_reg   <= CAUSE_NONE;
      drain_reg   <= '0;
      step_reg    <= '0;
      cov_acc_reg <= '0;
      done_reg    <= 1'b0;
      ovf_reg     <= 1'b0;
    end else begin
      if (fifo_drop) ovf_reg <= 1'b1;
      unique case (state_reg)
        ST_IDLE: begin
          if (start_i) state_reg <= ST_RUN;
        end
        ST_RUN: begin
          if (simlen_hit) begin
            state_reg <= ST_DONE;
            cause_reg <= CAUSE_SIMLEN;
            done_reg  <= 1'b1;
          end else begin
            cov_acc_reg <= cov_acc_reg | cov_i;
            step_reg    <= step_reg + 32'd1;
            if (hit_stop || (hit_trap && cfg_stop_on_trap_i)) begin
              state_reg <= ST_DRAIN;
              drain_reg <= DRAIN_W'(DRAIN_CYCLES);
              cause_reg <= hit_stop ? CAUSE_STOP : CAUSE_TRAP;
            end
          end
        end
        ST_DRAIN: begin
          if (simlen_hit) begin
            state_reg <= ST_DONE;
            cause_reg <= CAUSE_SIMLEN;
            done_reg  <= 1'b1;
          end else if (drain_reg == '0) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end else begin
            drain_reg   <= drain_reg - DRAIN_W'(1);
            cov_acc_reg <= cov_acc_reg | cov_i;
            step_reg    <= step_reg + 32'd1;
          end
        end
        default: begin
          // DONE holds everything until reset; the queue keeps draining.
        end
      endcase
    end
  end

  assign ev_kind_o = head_kind;
  assign cov_acc_o = cov_acc_reg;
  assign step_o    = step_reg;
  assign state_o   = state_reg;
  assign done_o    = done_reg;
  assign cause_o   = cause_reg;
  assign ovf_o     = ovf_reg;

endmodule

// File: tb/tb_mmio_sig_ctrl.sv
`timescale 1ns/1ps
module tb_mmio_sig_ctrl;
  import mmio_sig_pkg::*;

  localparam int ADDR_W = 32, DATA_W = 64, COV_W = 7283;
  localparam int DRAIN_CYCLES = 50, FIFO_DEPTH = 4;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              start_i = 1'b0;
  logic [31:0]       cfg_simlen_i = '0;
  logic              cfg_stop_on_trap_i = 1'b0;
  logic              mmio_req_i = 1'b0, mmio_we_i = 1'b0;
  logic [ADDR_W-1:0] mmio_addr_i = '0;
  logic [DATA_W-1:0] mmio_wdata_i = '0, mmio_wdata_t0_i = '0;
  logic [COV_W-1:0]  cov_i = '0;
  logic              ev_valid_o, ev_ready_i = 1'b1;
  logic [2:0]        ev_kind_o;
  logic [15:0]       ev_idx_o;
  logic [DATA_W-1:0] ev_data_o, ev_data_t0_o;
  logic [COV_W-1:0]  cov_acc_o;
  logic [31:0]       step_o;
  logic [1:0]        state_o, cause_o;
  logic              done_o, ovf_o;

  always #5 clk_i = ~clk_i;

  mmio_sig_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .COV_W(COV_W),
    .DRAIN_CYCLES(DRAIN_CYCLES), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .cfg_simlen_i(cfg_simlen_i), .cfg_stop_on_trap_i(cfg_stop_on_trap_i),
    .mmio_req_i(mmio_req_i), .mmio_we_i(mmio_we_i), .mmio_addr_i(mmio_addr_i),
    .mmio_wdata_i(mmio_wdata_i), .mmio_wdata_t0_i(mmio_wdata_t0_i),
    .cov_i(cov_i), .ev_valid_o(ev_valid_o), .ev_ready_i(ev_ready_i),
    .ev_kind_o(ev_kind_o), .ev_idx_o(ev_idx_o), .ev_data_o(ev_data_o),
    .ev_data_t0_o(ev_data_t0_o), .cov_acc_o(cov_acc_o), .step_o(step_o),
    .state_o(state_o), .done_o(done_o), .cause_o(cause_o), .ovf_o(ovf_o)
  );

  int tests_run = 0;
  int tests_failed = 0;

  typedef logic [191:0] cmp_t;

  task automatic chk(input string name, input cmp_t act, input cmp_t exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Head of the event port as one value; stop/trap carry no defined index.
  function automatic cmp_t ev_now();
    logic [15:0] idx;
    idx = ev_idx_o;
    if (ev_kind_o == EV_STOP || ev_kind_o == EV_TRAP) idx = '0;
    return cmp_t'({ev_valid_o, ev_kind_o, idx, ev_data_o, ev_data_t0_o});
  endfunction

  function automatic cmp_t ev_exp(input logic [2:0] k, input logic [15:0] idx,
                                  input logic [63:0] d, input logic [63:0] t);
    return cmp_t'({1'b1, k, idx, d, t});
  endfunction

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic bus(input logic req, input logic we, input logic [31:0] addr,
                     input logic [63:0] d, input logic [63:0] t);
    mmio_req_i = req; mmio_we_i = we; mmio_addr_i = addr;
    mmio_wdata_i = d; mmio_wdata_t0_i = t;
  endtask

  task automatic idle_bus();
    bus(1'b0, 1'b0, 32'h0, 64'h0, 64'h0);
  endtask

  task automatic do_reset();
    idle_bus(); start_i = 1'b0; cov_i = '0; rst_i = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
  endtask

  task automatic do_start();
    start_i = 1'b1; tick(); start_i = 1'b0;
  endtask

  typedef struct {
    logic        req, we;
    logic [31:0] addr;
    logic [63:0] data, t0;
    logic        exp_v;
    logic [2:0]  exp_kind;
    logic [15:0] exp_idx;
  } vec_t;

  function automatic vec_t mkv(input logic req, input logic we, input logic [31:0] a,
                               input logic [63:0] d, input logic [63:0] t, input logic v,
                               input logic [2:0] k, input logic [15:0] i);
    vec_t r;
    r.req = req; r.we = we; r.addr = a; r.data = d; r.t0 = t;
    r.exp_v = v; r.exp_kind = k; r.exp_idx = i;
    return r;
  endfunction

  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] idx;
    logic [63:0] d, t;
  } mev_t;

  vec_t vecs [10];
  mev_t q [$];
  logic [15:0] m_idx [3];
  logic [COV_W-1:0] m_cov;
  logic m_ovf;
  int m_step, cnt;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    // ---------------- reset state
    do_reset();
    chk("rst_state", cmp_t'(state_o), cmp_t'(ST_IDLE));
    chk("rst_flags", cmp_t'({ev_valid_o, done_o, ovf_o, cause_o}), cmp_t'(0));
    chk("rst_step", cmp_t'(step_o), cmp_t'(0));
    chk("rst_cov", cmp_t'(|cov_acc_o), cmp_t'(0));
    tick();
    chk("idle_holds", cmp_t'(state_o), cmp_t'(ST_IDLE));

    // ---------------- table-driven single writes, consumer always ready
    vecs[0] = mkv(1, 1, SIG_ADDR_REG,    64'hA,  64'h1,  1, EV_REG,    16'd1);
    vecs[1] = mkv(1, 1, SIG_ADDR_REG,    64'hB,  64'h1,  1, EV_REG,    16'd2);
    vecs[2] = mkv(1, 1, SIG_ADDR_FREG,   64'h55, 64'h0,  1, EV_FREG,   16'd0);
    vecs[3] = mkv(1, 1, SIG_ADDR_STREAM, 64'h77, 64'hF0, 1, EV_STREAM, 16'd0);
    vecs[4] = mkv(1, 0, SIG_ADDR_REG,    64'h1,  64'h0,  0, EV_REG,    16'd0);
    vecs[5] = mkv(0, 1, SIG_ADDR_REG,    64'h2,  64'h0,  0, EV_REG,    16'd0);
    vecs[6] = mkv(1, 1, 32'h6000_0014,   64'h3,  64'h0,  0, EV_REG,    16'd0);
    vecs[7] = mkv(1, 0, SIG_ADDR_TRAP,   64'h33, 64'h2,  1, EV_TRAP,   16'd0);
    vecs[8] = mkv(1, 1, SIG_ADDR_FREG,   64'h99, 64'h0,  1, EV_FREG,   16'd1);
    vecs[9] = mkv(1, 1, SIG_ADDR_REG,    64'hC,  64'h0,  1, EV_REG,    16'd3);
    do_start();
    for (int i = 0; i < 10; i++) begin
      bus(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].t0);
      tick();
      idle_bus();
      if (vecs[i].exp_v)
        chk($sformatf("vec%0d_ev", i), ev_now(),
            ev_exp(vecs[i].exp_kind, vecs[i].exp_idx, vecs[i].data, vecs[i].t0));
      else
        chk($sformatf("vec%0d_noev", i), cmp_t'(ev_valid_o), cmp_t'(0));
    end
    chk("vec_state_run", cmp_t'({state_o, cause_o, ovf_o}), cmp_t'({ST_RUN, CAUSE_NONE, 1'b0}));

    // ---------------- STOP at step 5 and drain timing
    do_reset(); do_start();
    repeat (5) tick();
    chk("stop_pre_step", cmp_t'(step_o), cmp_t'(5));
    bus(1, 1, SIG_ADDR_STOP, 64'h5A, 64'h3);
    tick(); idle_bus();
    chk("stop_ev", ev_now(), ev_exp(EV_STOP, 16'd0, 64'h5A, 64'h3));
    chk("stop_state", cmp_t'({state_o, cause_o}), cmp_t'({ST_DRAIN, CAUSE_STOP}));
    cnt = 1;
    while (!done_o && cnt < 200) begin tick(); cnt++; end
    chk("stop_latency", cmp_t'(cnt), cmp_t'(DRAIN_CYCLES + 2));
    chk("stop_final", cmp_t'({state_o, cause_o}), cmp_t'({ST_DONE, CAUSE_STOP}));
    chk("stop_step", cmp_t'(step_o), cmp_t'(56));
    bus(1, 1, SIG_ADDR_REG, 64'h1, 64'h0); tick(); idle_bus(); tick();
    chk("done_terminal", cmp_t'({state_o, done_o, ev_valid_o, step_o}),
        cmp_t'({ST_DONE, 1'b1, 1'b0, 32'd56}));

    // ---------------- TRAP entering drain, dumps ignored while draining
    do_reset(); cfg_stop_on_trap_i = 1'b1; do_start();
    bus(1, 0, SIG_ADDR_TRAP, 64'h77, 64'h8);
    tick(); idle_bus();
    chk("trap_ev", ev_now(), ev_exp(EV_TRAP, 16'd0, 64'h77, 64'h8));
    chk("trap_state", cmp_t'({state_o, cause_o}), cmp_t'({ST_DRAIN, CAUSE_TRAP}));
    bus(1, 1, SIG_ADDR_REG, 64'hDD, 64'h0);
    tick(); idle_bus();
    chk("drain_reg_ignored", cmp_t'(ev_valid_o), cmp_t'(0));
    cfg_stop_on_trap_i = 1'b0;

    // ---------------- SIMLEN with one-hot coverage
    do_reset(); cfg_simlen_i = 32'd10; do_start();
    cnt = 0;
    while (!done_o && cnt < 40) begin
      cov_i = '0; cov_i[cnt] = 1'b1; tick(); cnt++;
    end
    cov_i = '0;
    chk("simlen_cycles", cmp_t'(cnt), cmp_t'(10));
    chk("simlen_final", cmp_t'({state_o, cause_o}), cmp_t'({ST_DONE, CAUSE_SIMLEN}));
    chk("simlen_step", cmp_t'(step_o), cmp_t'(9));
    chk("simlen_cov_lo", cmp_t'(cov_acc_o[9:0]), cmp_t'(10'h1FF));
    chk("simlen_cov_pop", cmp_t'($countones(cov_acc_o)), cmp_t'(9));
    cfg_simlen_i = '0;

    // ---------------- overflow with consumer stalled
    do_reset(); do_start(); ev_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus(1, 1, SIG_ADDR_STREAM, 64'h100 + 64'(i), 64'(i)); cov_i[3] = 1'b1; tick();
    end
    idle_bus(); cov_i = '0;
    chk("ovf_set", cmp_t'(ovf_o), cmp_t'(1));
    chk("ovf_head_hold", ev_now(), ev_exp(EV_STREAM, 16'd0, 64'h100, 64'h0));
    tick();
    chk("ovf_head_stable", ev_now(), ev_exp(EV_STREAM, 16'd0, 64'h100, 64'h0));
    ev_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_pop%0d", i), ev_now(),
          ev_exp(EV_STREAM, 16'(i), 64'h100 + 64'(i), 64'(i)));
      tick();
    end
    chk("ovf_drained", cmp_t'(ev_valid_o), cmp_t'(0));
    bus(1, 1, SIG_ADDR_STREAM, 64'h200, 64'h0); tick(); idle_bus();
    chk("ovf_next_idx", ev_now(), ev_exp(EV_STREAM, 16'd6, 64'h200, 64'h0));

    // ---------------- reset in the middle of DRAIN
    ev_ready_i = 1'b0;
    bus(1, 1, SIG_ADDR_REG, 64'h1, 64'h0); tick();
    bus(1, 1, SIG_ADDR_STOP, 64'h2, 64'h0); tick(); idle_bus();
    repeat (3) tick();
    chk("mid_drain_pre", cmp_t'({state_o, ev_valid_o, ovf_o, cov_acc_o[3]}),
        cmp_t'({ST_DRAIN, 1'b1, 1'b1, 1'b1}));
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    chk("mid_drain_rst", cmp_t'({state_o, ev_valid_o, ovf_o, cause_o, done_o}),
        cmp_t'({ST_IDLE, 1'b0, 1'b0, CAUSE_NONE, 1'b0}));
    chk("mid_drain_rst_cov", cmp_t'({|cov_acc_o, step_o}), cmp_t'(0));
    ev_ready_i = 1'b1; do_start();
    bus(1, 1, SIG_ADDR_REG, 64'hE, 64'h0); tick(); idle_bus();
    chk("rst_reg_idx", ev_now(), ev_exp(EV_REG, 16'd1, 64'hE, 64'h0));

    // ---------------- randomized traffic against a queue model
    do_reset(); do_start();
    q.delete();
    m_idx[0] = 16'd1; m_idx[1] = 16'd0; m_idx[2] = 16'd0;
    m_cov = '0; m_ovf = 1'b0; m_step = 0;
    for (int c = 0; c < 3000; c++) begin
      int r, thr;
      logic has_ev;
      mev_t e;
      logic [31:0] addr;
      if (q.size() > 0) chk("rnd_ev", ev_now(), ev_exp(q[0].kind, q[0].idx, q[0].d, q[0].t));
      else              chk("rnd_empty", cmp_t'(ev_valid_o), cmp_t'(0));
      thr = ((c / 200) % 3 == 0) ? 20 : (((c / 200) % 3 == 1) ? 55 : 95);
      ev_ready_i = ($urandom_range(0, 99) < thr);
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: addr = SIG_ADDR_REG;
        3:       addr = SIG_ADDR_FREG;
        4, 5:    addr = SIG_ADDR_STREAM;
        6:       addr = SIG_ADDR_TRAP;
        default: addr = ($urandom_range(0, 1) == 0) ? 32'h6000_0004 : 32'h6000_0028;
      endcase
      bus((r < 8) ? 1'b1 : ($urandom_range(0, 3) == 0), $urandom_range(0, 4) != 0, addr,
          {$urandom, $urandom}, {$urandom, $urandom});
      cov_i = '0;
      for (int b = 0; b < 3; b++) cov_i[$urandom_range(0, COV_W - 1)] = 1'b1;
      // model: consumer takes the head, then the new event is offered
      has_ev = 1'b0;
      e = '0;
      e.d = mmio_wdata_i; e.t = mmio_wdata_t0_i;
      if (mmio_req_i && addr == SIG_ADDR_TRAP) begin
        has_ev = 1'b1; e.kind = EV_TRAP;
      end else if (mmio_req_i && mmio_we_i) begin
        for (int k = 0; k < 3; k++) begin
          if (addr == SIG_DUMP_ADDR[k]) begin
            has_ev = 1'b1; e.kind = 3'(k); e.idx = m_idx[k];
            m_idx[k] = m_idx[k] + 16'd1;
          end
        end
      end
      if (ev_ready_i && q.size() > 0) void'(q.pop_front());
      if (has_ev) begin
        if (q.size() < FIFO_DEPTH) q.push_back(e);
        else m_ovf = 1'b1;
      end
      m_cov = m_cov | cov_i;
      m_step++;
      tick();
    end
    idle_bus(); cov_i = '0;
    chk("rnd_step", cmp_t'(step_o), cmp_t'(m_step));
    chk("rnd_ovf", cmp_t'(ovf_o), cmp_t'(m_ovf));
    chk("rnd_state", cmp_t'(state_o), cmp_t'(ST_RUN));
    tests_run++;
    if (cov_acc_o !== m_cov) begin
      tests_failed++;
      $display("FAIL rnd_cov: got %0d bits set, expected %0d bits set",
               $countones(cov_acc_o), $countones(m_cov));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
